// File: rtl/trigger_scheduler.sv
// Round-robin trigger scheduler: grants one requester at a time and fires its channel mask aligned to BSYNC strobes.
// req_ready is a same-cycle accept pulse in IDLE; trig_out/done/abort are decoded from registered state.
module trigger_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int NUM_CH  = 4
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*NUM_CH-1:0]   req_ch_mask,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [7:0]                  cfg_repeat,
   input  logic [7:0]                  cfg_interval,
   input  logic                        bsync_event,
   input  logic                        bsync_ready,
   input  logic [3*NUM_CH-1:0]         ch_state,
   output logic [NUM_CH-1:0]           trig_out,
   output logic                        busy,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id,
   output logic                        done,
   output logic                        abort
);

   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_ARM,
      WAIT_BSYNC,
      FIRE,
      GAP
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_CH-1:0]   mask_q;
   logic [7:0]          rem_q;
   logic [7:0]          ivl_q;
   logic [7:0]          gap_q;
   logic [IW-1:0]       ptr_q;
   logic [IW-1:0]       gid_q;
   logic                done_q, done_d;
   logic                abort_q, abort_d;

   logic                gnt_vld;
   logic [IW-1:0]       gnt_idx;
   logic [IW-1:0]       idx;
   logic                grant;
   logic [NUM_CH-1:0]   mask_sel;
   logic [NUM_CH-1:0]   armed;
   logic                all_armed;

   // Search starts at the pointer so the last winner has lowest priority
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      idx     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = IW'((int'(ptr_q) + i) % NUM_REQ);
         if (!gnt_vld && req_valid[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   always_comb begin
      mask_sel = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         if (gnt_idx == IW'(r)) mask_sel = req_ch_mask[r*NUM_CH +: NUM_CH];
      end
   end

   always_comb begin
      armed = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         armed[c] = (ch_state[3*c +: 3] == 3'd1);
      end
   end

   assign all_armed = &(~mask_q | armed);
   assign grant     = rstn && (state_q == IDLE) && bsync_ready && gnt_vld;
   assign req_ready = grant ? (NUM_REQ'(1) << gnt_idx) : '0;

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      abort_d = 1'b0;
      if (state_q != IDLE && !bsync_ready) begin
         state_d = IDLE;
         abort_d = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant) begin
                  if (mask_sel == '0) done_d  = 1'b1;
                  else                state_d = WAIT_ARM;
               end
            end
            WAIT_ARM: begin
               if (all_armed) state_d = WAIT_BSYNC;
            end
            WAIT_BSYNC: begin
               if (bsync_event) state_d = FIRE;
            end
            FIRE: begin
               if (rem_q <= 8'd1) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else if (ivl_q == 8'd0) begin
                  state_d = WAIT_ARM;
               end else begin
                  state_d = GAP;
               end
            end
            GAP: begin
               if (bsync_event && gap_q <= 8'd1) state_d = WAIT_ARM;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         mask_q  <= '0;
         rem_q   <= 8'd0;
         ivl_q   <= 8'd0;
         gap_q   <= 8'd0;
         ptr_q   <= '0;
         gid_q   <= '0;
         done_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         abort_q <= abort_d;
         if (grant) begin
            mask_q <= mask_sel;
            rem_q  <= (cfg_repeat == 8'd0) ? 8'd1 : cfg_repeat;
            ivl_q  <= cfg_interval;
            gid_q  <= gnt_idx;
            ptr_q  <= (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + IW'(1);
         end
         if (state_q == FIRE && rem_q != 8'd0) rem_q <= rem_q - 8'd1;
         // Gap counter reloads on every fire and only counts strobes while in GAP
         if (state_q == FIRE) begin
            gap_q <= ivl_q;
         end else if (state_q == GAP && bsync_event && gap_q != 8'd0) begin
            gap_q <= gap_q - 8'd1;
         end
      end
   end

   assign trig_out = (state_q == FIRE) ? mask_q : '0;
   assign busy     = (state_q != IDLE);
   assign grant_id = gid_q;
   assign done     = done_q;
   assign abort    = abort_q;

endmodule

// File: tb/tb_trigger_scheduler.sv
// Directed bench for trigger_scheduler: grant order, BSYNC-aligned firing, repeat/gap timing, abort and reset.
module tb_trigger_scheduler;

   logic        clk;
   logic        rstn;
   logic [3:0]  req_valid;
   logic [15:0] req_ch_mask;
   logic [3:0]  req_ready;
   logic [7:0]  cfg_repeat;
   logic [7:0]  cfg_interval;
   logic        bsync_event;
   logic        bsync_ready;
   logic [11:0] ch_state;
   logic [3:0]  trig_out;
   logic        busy;
   logic [1:0]  grant_id;
   logic        done;
   logic        abort;

   int n_chk  = 0;
   int n_fail = 0;

   int cyc = 0;
   int trig_cnt = 0;
   int done_cnt = 0;
   logic [3:0] last_trig = '0;
   int tq[$];
   int t_base, d_base, sp1, sp2;

   trigger_scheduler #(.NUM_REQ(4), .NUM_CH(4)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .req_valid    (req_valid),
      .req_ch_mask  (req_ch_mask),
      .req_ready    (req_ready),
      .cfg_repeat   (cfg_repeat),
      .cfg_interval (cfg_interval),
      .bsync_event  (bsync_event),
      .bsync_ready  (bsync_ready),
      .ch_state     (ch_state),
      .trig_out     (trig_out),
      .busy         (busy),
      .grant_id     (grant_id),
      .done         (done),
      .abort        (abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Activity monitor, sampled shortly after each rising edge
   always @(posedge clk) begin
      #2;
      cyc++;
      if (trig_out != 4'd0) begin
         trig_cnt++;
         last_trig = trig_out;
         tq.push_back(cyc);
      end
      if (done === 1'b1) done_cnt++;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Each period: idle cycles, then a one-cycle strobe; returns on the negedge after the strobe edge
   task automatic run_bsync(input int n, input int period);
      for (int p = 0; p < n; p++) begin
         for (int k = 0; k < period - 1; k++) @(negedge clk);
         bsync_event = 1'b1;
         @(negedge clk);
         bsync_event = 1'b0;
      end
   endtask

   initial begin
      rstn         = 1'b0;
      req_valid    = 4'b1111;
      req_ch_mask  = '0;
      cfg_repeat   = 8'd1;
      cfg_interval = 8'd0;
      bsync_event  = 1'b0;
      bsync_ready  = 1'b1;
      ch_state     = {4{3'd1}};

      // Reset state
      repeat (3) @(negedge clk);
      check_val("rst_busy", busy, 0);
      check_val("rst_trig", trig_out, 0);
      check_val("rst_done", done, 0);
      check_val("rst_abort", abort, 0);
      check_val("rst_gid", grant_id, 0);
      check_val("rst_ready", req_ready, 0);
      req_valid = 4'b0000;
      rstn = 1'b1;
      @(negedge clk);

      // Single request, mask 0101
      req_valid = 4'b0001;
      req_ch_mask[3:0] = 4'b0101;
      cfg_repeat = 8'd1;
      #1 check_val("single_ready", req_ready, 4'b0001);
      @(negedge clk);
      req_valid = 4'b0000;
      check_val("single_busy", busy, 1);
      check_val("single_gid", grant_id, 0);
      check_val("single_ready_off", req_ready, 0);
      repeat (3) @(negedge clk);
      check_val("single_no_early", trig_out, 0);
      bsync_event = 1'b1;
      @(negedge clk);
      bsync_event = 1'b0;
      check_val("single_trig", trig_out, 4'b0101);
      @(negedge clk);
      check_val("single_trig_off", trig_out, 0);
      check_val("single_done", done, 1);
      check_val("single_idle", busy, 0);

      // Repeat 3, interval 2; config changed after grant must not matter
      req_valid = 4'b0010;
      req_ch_mask[7:4] = 4'b1010;
      cfg_repeat = 8'd3;
      cfg_interval = 8'd2;
      #1 check_val("rep_ready", req_ready, 4'b0010);
      @(negedge clk);
      req_valid = 4'b0000;
      cfg_repeat = 8'd7;
      cfg_interval = 8'd0;
      tq.delete();
      d_base = done_cnt;
      run_bsync(9, 6);
      repeat (2) @(negedge clk);
      check_val("rep_count", tq.size(), 3);
      sp1 = (tq.size() >= 2) ? tq[1] - tq[0] : -1;
      sp2 = (tq.size() >= 3) ? tq[2] - tq[1] : -1;
      check_val("rep_space1", sp1, 18);
      check_val("rep_space2", sp2, 18);
      check_val("rep_done", done_cnt - d_base, 1);
      check_val("rep_mask", last_trig, 4'b1010);
      check_val("rep_idle", busy, 0);

      // Fairness after reset, all requesters held, empty masks
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      req_ch_mask = '0;
      cfg_repeat = 8'd1;
      req_valid = 4'b1111;
      t_base = trig_cnt;
      for (int k = 0; k < 5; k++) begin
         #1 check_val("rr_ready", req_ready, 32'(1) << (k % 4));
         @(negedge clk);
         check_val("rr_gid", grant_id, k % 4);
         check_val("rr_done", done, 1);
      end
      req_valid = 4'b0000;
      check_val("mask0_no_trig", trig_cnt - t_base, 0);

      // Arm gating: channel 1 not armed, unmasked channel 3 ignored
      req_valid = 4'b0100;
      req_ch_mask[11:8] = 4'b0011;
      ch_state[5:3] = 3'd2;
      ch_state[11:9] = 3'd0;
      #1 check_val("arm_ready", req_ready, 4'b0100);
      @(negedge clk);
      req_valid = 4'b0000;
      t_base = trig_cnt;
      run_bsync(3, 6);
      check_val("arm_hold", trig_cnt - t_base, 0);
      check_val("arm_busy", busy, 1);
      ch_state[5:3] = 3'd1;
      @(negedge clk);
      run_bsync(1, 6);
      check_val("arm_trig", trig_out, 4'b0011);
      @(negedge clk);
      check_val("arm_done", done, 1);
      ch_state = {4{3'd1}};

      // Abort during GAP
      req_valid = 4'b1000;
      req_ch_mask[15:12] = 4'b1000;
      cfg_repeat = 8'd2;
      cfg_interval = 8'd3;
      #1 check_val("abt_ready", req_ready, 4'b1000);
      @(negedge clk);
      req_valid = 4'b0000;
      t_base = trig_cnt;
      run_bsync(2, 6);
      check_val("abt_in_gap", busy, 1);
      bsync_ready = 1'b0;
      @(negedge clk);
      check_val("abt_pulse", abort, 1);
      check_val("abt_busy", busy, 0);
      check_val("abt_trig", trig_out, 0);
      check_val("abt_one_trig", trig_cnt - t_base, 1);
      req_ch_mask = '0;
      req_valid = 4'b1111;
      #1 check_val("abt_no_grant", req_ready, 0);
      @(negedge clk);
      check_val("abt_pulse_end", abort, 0);
      check_val("abt_still_idle", busy, 0);
      bsync_ready = 1'b1;
      #1 check_val("abt_ptr_kept", req_ready, 4'b0001);
      @(negedge clk);
      req_valid = 4'b0000;
      check_val("abt_next_done", done, 1);

      // repeat = 0 gives exactly one trigger
      req_valid = 4'b0010;
      req_ch_mask[7:4] = 4'b0100;
      cfg_repeat = 8'd0;
      cfg_interval = 8'd0;
      #1 check_val("rep0_ready", req_ready, 4'b0010);
      @(negedge clk);
      req_valid = 4'b0000;
      t_base = trig_cnt;
      d_base = done_cnt;
      run_bsync(4, 6);
      @(negedge clk);
      check_val("rep0_trigs", trig_cnt - t_base, 1);
      check_val("rep0_done", done_cnt - d_base, 1);
      check_val("rep0_mask", last_trig, 4'b0100);

      // Reset mid-FIRE
      req_valid = 4'b0100;
      req_ch_mask[11:8] = 4'b0110;
      cfg_repeat = 8'd5;
      #1 check_val("rstf_ready", req_ready, 4'b0100);
      @(negedge clk);
      req_valid = 4'b0000;
      run_bsync(1, 6);
      check_val("rstf_fire", trig_out, 4'b0110);
      rstn = 1'b0;
      @(negedge clk);
      check_val("rstf_trig", trig_out, 0);
      check_val("rstf_busy", busy, 0);
      check_val("rstf_no_abort", abort, 0);
      req_valid = 4'b1100;
      #1 check_val("rstf_ready_gated", req_ready, 0);
      @(negedge clk);
      rstn = 1'b1;
      #1 check_val("rstf_first_grant", req_ready, 4'b0100);
      @(negedge clk);
      req_valid = 4'b0000;
      check_val("rstf_gid", grant_id, 2);
      check_val("rstf_busy_after", busy, 1);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/trigger_scheduler.md
TRIGGER_SCHEDULER -- requirements
Module: trigger_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of trigger requesters (2..8).
REQ-002 Parameter NUM_CH, default 4, number of downstream trigger channels (1..16).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester trigger request, level, held until accepted.
REQ-006 req_ch_mask  input  NUM_REQ*NUM_CH  channel mask per requester; slice r = bits [r*NUM_CH +: NUM_CH].
REQ-007 req_ready  output  NUM_REQ  one-cycle accept pulse to the granted requester.
REQ-008 cfg_repeat  input  8  triggers per accepted request; 0 treated as 1.
REQ-009 cfg_interval  input  8  bsync_event periods skipped between repeats.
REQ-010 bsync_event  input  1  one-cycle BSYNC alignment strobe.
REQ-011 bsync_ready  input  1  BSYNC subsystem locked.
REQ-012 ch_state  input  3*NUM_CH  per-channel state; value 1 = armed (waiting for trigger edge).
REQ-013 trig_out  output  NUM_CH  trigger pulses to channels.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 grant_id  output  $clog2(NUM_REQ)  index of the current/last granted requester.
REQ-016 done  output  1  one-cycle pulse when a request completes normally.
REQ-017 abort  output  1  one-cycle pulse when a request is aborted.

Function
REQ-018 FSM states: IDLE, WAIT_ARM, WAIT_BSYNC, FIRE, GAP; state register resets to IDLE.
REQ-019 IDLE: if bsync_ready=1 and any req_valid=1, grant round-robin, searching from (last grant+1) mod NUM_REQ; pulse req_ready[g]; latch mask, cfg_repeat (as remaining count) and cfg_interval; go to WAIT_ARM next cycle.
REQ-020 Config inputs are sampled only at grant; later changes do not affect the active request.
REQ-021 Latched mask all-zero: assert done one cycle after grant with no trig_out activity; return to IDLE.
REQ-022 WAIT_ARM: advance to WAIT_BSYNC when every masked channel has ch_state==1; unmasked channels are ignored.
REQ-023 WAIT_BSYNC: on bsync_event go to FIRE; a bsync_event in the cycle of entering WAIT_BSYNC is not counted.
REQ-024 FIRE: trig_out = latched mask for exactly one cycle; otherwise trig_out = 0; decrement remaining.
REQ-025 After FIRE: remaining==0 -> pulse done, go to IDLE; else interval==0 -> WAIT_ARM; else GAP.
REQ-026 GAP: count bsync_event strobes; after cfg_interval strobes go to WAIT_ARM.
REQ-027 bsync_ready=0 in any non-IDLE state: next cycle go to IDLE, trig_out=0, pulse abort; the request is not retried.
REQ-028 The grant pointer updates only on a grant; abort and done do not move it.
REQ-029 Remaining and interval counters are 8-bit; no wrap-around occurs because the counters stop at 0.
REQ-030 Only one request is active at a time; req_valid is not sampled outside IDLE.
REQ-031 req_ready is never asserted for a requester with req_valid=0, and never for more than one requester per cycle.

Reset
REQ-032 While rstn=0: state IDLE, trig_out=0, req_ready=0, done=0, abort=0, busy=0, grant_id=0, round-robin pointer set so requester 0 has first priority.
REQ-033 Reset asserted mid-request terminates it immediately, without an abort pulse; the first grant after reset goes to the lowest-index valid requester.

Verification
REQ-034 Single request: req_valid[0]=1, mask=4'b0101, repeat=1, channels armed -> req_ready[0] pulse, trig_out=4'b0101 for 1 cycle on the cycle after bsync_event, then done.
REQ-035 Repeat: repeat=3, interval=2 -> three trig_out pulses, spaced 3 bsync periods apart, then one done pulse.
REQ-036 Fairness: req_valid=4'b1111 held -> grants in order 0,1,2,3,0; each requester is granted exactly once per 4 grants.
REQ-037 Arm gating: mask=4'b0011 with ch_state[1]=2 -> no trig_out until ch_state[1]=1, then fire on the next bsync_event.
REQ-038 Abort: drop bsync_ready during GAP -> abort pulse, trig_out stays 0, busy=0 the following cycle, pointer unchanged.
REQ-039 Edge cases: mask=0 -> done with no trig_out; repeat=0 -> exactly one trigger; rstn=0 mid-FIRE -> trig_out=0 on the next cycle.
